// File: rtl/stack_lifo.sv
// rtl/stack_lifo.sv - LIFO data stack with full/empty protection and registered pop read-out
//
// Optional feature macro: STACK_ERR_EN (sticky overflow/underflow flag on err; tied to 0 otherwise)
//
// Parameters:
//   N          pointer width, DEPTH = 2**N entries
//   W          data word width
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   push       write request, din pushed this cycle
//   pop        read request, top word removed this cycle
//   din        data to push
//   dout       last popped word (registered)
//   dout_valid one-cycle pulse when dout was updated by an accepted pop
//   count      stored word count, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   err        sticky overflow/underflow flag
module stack_lifo #(
  parameter int N = 10,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  output logic [N:0]   count,
  output logic         full,
  output logic         empty,
  output logic         err
);

  localparam int DEPTH = 2 ** N;
  localparam logic [N:0] FULL_CNT = {1'b1, {N{1'b0}}};

  logic [W-1:0] mem [0:DEPTH-1];

  logic         rd_en;
  logic         wr_en;
  logic [N-1:0] top_idx;
  logic [N-1:0] wr_idx;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // When full, count[N-1:0] is 0, so the subtraction wraps to DEPTH-1,
  // which is exactly the top entry.
  assign top_idx = count[N-1:0] - N'(1);

  // A pop is only honoured when there is something to pop. A push is
  // honoured when there is room, or when it pairs with a pop: if the stack
  // is non-empty that is a replace-top, if empty the pop is dropped and the
  // push lands in slot 0.
  assign rd_en  = pop & ~empty;
  assign wr_en  = push & (pop | ~full);
  assign wr_idx = rd_en ? top_idx : count[N-1:0];

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_en;
      if (rd_en) begin
        // Old top is read before the same-edge replace-top write lands.
        dout <= mem[top_idx];
      end
      if (wr_en && !rd_en) begin
        count <= count + (N+1)'(1);
      end else if (rd_en && !wr_en) begin
        count <= count - (N+1)'(1);
      end
    end
  end

`ifdef STACK_ERR_EN
  logic overflow;
  logic underflow;

  assign overflow  = push & ~pop & full;
  // Includes the empty push+pop case where only the pop is rejected.
  assign underflow = pop & empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (overflow || underflow) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_stack_lifo.sv
// tb/tb_stack_lifo.sv - scoreboard bench for stack_lifo (N=2, W=8)
module tb_stack_lifo;

  localparam int N = 2;
  localparam int W = 8;

`ifdef STACK_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic [N:0]   count;
  logic         full;
  logic         empty;
  logic         err;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  int mon_cnt = 0;
  logic [W-1:0] exp_q[$];

  stack_lifo #(.N(N), .W(W)) dut (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(dout),
    .dout_valid(dout_valid),
    .count(count),
    .full(full),
    .empty(empty),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic p, input logic q, input logic [W-1:0] d);
    push = p;
    pop  = q;
    din  = d;
    @(posedge clk);
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
    din  = '0;
  endtask

  task automatic expect_pop(input logic [W-1:0] v);
    exp_q.push_back(v);
    exp_cnt++;
  endtask

  // Monitor: every dout_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && dout_valid) begin
      mon_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_dout_valid", 1, 0);
      end else begin
        chk("pop_data", int'(dout), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_err", int'(err), 0);

    // Fill and drain
    step(1, 0, 8'h11);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    step(1, 0, 8'h44);
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 4);
    expect_pop(8'h44); step(0, 1, 8'h00); chk("drain_v0", int'(dout_valid), 1);
    expect_pop(8'h33); step(0, 1, 8'h00); chk("drain_v1", int'(dout_valid), 1);
    expect_pop(8'h22); step(0, 1, 8'h00); chk("drain_v2", int'(dout_valid), 1);
    expect_pop(8'h11); step(0, 1, 8'h00); chk("drain_v3", int'(dout_valid), 1);
    chk("drain_empty", int'(empty), 1);
    chk("drain_count", int'(count), 0);
    step(0, 0, 8'h00);
    chk("idle_no_valid", int'(dout_valid), 0);

    // Underflow
    step(0, 1, 8'h00);
    chk("uf_dout_valid", int'(dout_valid), 0);
    chk("uf_dout_hold", int'(dout), 8'h11);
    chk("uf_count", int'(count), 0);
    chk("uf_err", int'(err), int'(ERR_ON));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("uf_err_cleared", int'(err), 0);

    // Overflow
    step(1, 0, 8'h11);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    step(1, 0, 8'h44);
    step(1, 0, 8'h55);
    chk("of_count", int'(count), 4);
    chk("of_full", int'(full), 1);
    chk("of_err", int'(err), int'(ERR_ON));
    expect_pop(8'h44); step(0, 1, 8'h00);
    chk("of_pop_count", int'(count), 3);

    // Asynchronous reset mid-clock with count=3
    #2 rst = 1'b1;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_dout", int'(dout), 0);
    chk("arst_err", int'(err), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Replace-top
    step(1, 0, 8'h0A);
    step(1, 0, 8'h0B);
    expect_pop(8'h0B); step(1, 1, 8'hCC);
    chk("rt_dout_valid", int'(dout_valid), 1);
    chk("rt_count", int'(count), 2);
    expect_pop(8'hCC); step(0, 1, 8'h00);
    chk("rt_pop_count", int'(count), 1);
    expect_pop(8'h0A); step(0, 1, 8'h00);
    chk("rt_empty", int'(empty), 1);
    chk("rt_err", int'(err), 0);

    // Replace-top while full
    step(1, 0, 8'hA1);
    step(1, 0, 8'hA2);
    step(1, 0, 8'hA3);
    step(1, 0, 8'hA4);
    expect_pop(8'hA4); step(1, 1, 8'hB4);
    chk("rtf_count", int'(count), 4);
    chk("rtf_err", int'(err), 0);
    expect_pop(8'hB4); step(0, 1, 8'h00);
    expect_pop(8'hA3); step(0, 1, 8'h00);
    expect_pop(8'hA2); step(0, 1, 8'h00);
    expect_pop(8'hA1); step(0, 1, 8'h00);
    chk("rtf_empty", int'(empty), 1);

    // Empty push+pop
    step(1, 1, 8'h7E);
    chk("epp_count", int'(count), 1);
    chk("epp_no_valid", int'(dout_valid), 0);
    chk("epp_err", int'(err), int'(ERR_ON));
    expect_pop(8'h7E); step(0, 1, 8'h00);
    chk("epp_empty", int'(empty), 1);

    step(0, 0, 8'h00);
    chk("sb_drained", exp_q.size(), 0);
    chk("sb_pulse_count", mon_cnt, exp_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_lifo.md
# stack_lifo

Synchronous LIFO stack that stores words on `push` and returns them on `pop`. Its pointer moves up on a push and down on a pop. It is the storage-side consumer of the stack position counter in the Stack2 design, adding data storage, full/empty protection and a registered read-out path. Intended as the data stack for the Stack_Pos datapath.

## Interface
- `N`, 10, pointer width; depth `DEPTH` = 2**N entries.
- `W`, 8, data word width.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-high; clears all state.
- `push`  in  1  write request; `din` is pushed this cycle.
- `pop`  in  1  read request; top word is removed this cycle.
- `din`  in  W  data to push.
- `dout`  out  W  last popped word, registered.
- `dout_valid`  out  1  one-cycle pulse: `dout` updated by an accepted pop.
- `count`  out  N+1  number of stored words, 0..DEPTH.
- `full`  out  1  `count` == DEPTH.
- `empty`  out  1  `count` == 0.
- `err`  out  1  sticky overflow/underflow flag (see Configuration).

## Operation
- Storage: array `mem[0:DEPTH-1]`, W bits wide. The top of stack is `mem[count-1]`.
- Reset values: `count`=0, `dout`=0, `dout_valid`=0, `empty`=1, `full`=0, `err`=0. Memory contents are not reset.
- Push only, not full: `mem[count]` <= `din`; `count` <= `count`+1.
- Pop only, not empty: `dout` <= `mem[count-1]`; `dout_valid` <= 1; `count` <= `count`-1.
- Push and pop together, not empty (replace-top):
  - `dout` <= old top; `dout_valid` <= 1.
  - `mem[count-1]` <= `din`.
  - `count` unchanged.
  - This case is legal even when full.
- Push and pop together, empty: the pop is rejected and the push is accepted, so `count` goes 0->1. No `dout_valid`.
- Push while full (no pop): ignored. `count` and memory are unchanged. This is an overflow.
- Pop while empty (no push): ignored. `dout` holds its value; `dout_valid`=0. This is an underflow.
- `count` never wraps. It is saturated by the rejection rules above.
- `full` and `empty` are decoded combinationally from the registered `count`.
- Reset asserted mid-operation clears `count`, flags and `dout` immediately, independent of `clk`. Requests in the reset cycle are lost.

## Timing
- All state updates on the rising edge of `clk`.
- Pop latency is 1 cycle: `dout`/`dout_valid` are valid in the cycle after `pop` is sampled.
- `dout_valid` is high for exactly one cycle per accepted pop. Back-to-back pops give back-to-back pulses.
- `count`, `full` and `empty` reflect a request in the cycle after it is sampled.
- A push followed by a pop on the next cycle returns the just-pushed word; there is no read-after-write hazard.
- Throughput is one operation per cycle, with no stall.

## Configuration
- `STACK_ERR_EN` defined:
  - `err` is set on any overflow or underflow event and stays high until `rst`.
  - A rejected pop on an empty stack during a simultaneous push counts as underflow.
- `STACK_ERR_EN` undefined: `err` is tied to 0 and no error logic is synthesized. All other behaviour is identical.

## Test plan
Benches use `N`=2 (DEPTH 4), `W`=8, and `STACK_ERR_EN` defined.
- **Reset:** assert `rst` mid-clock with `count`=3 -> immediately `count`=0, `empty`=1, `dout`=0x00, `err`=0.
- **Fill and drain:**
  - Push 0x11, 0x22, 0x33, 0x44 -> `full`=1, `count`=4.
  - Then 4 pops -> `dout` = 0x44, 0x33, 0x22, 0x11 on consecutive cycles, each with `dout_valid`=1; `empty`=1 at the end.
- **Overflow:**
  - With full 0x11..0x44, push 0x55 -> `count` stays 4 and `err`=1.
  - A following pop returns 0x44.
- **Underflow:** when empty, pop -> `dout_valid`=0, `dout` unchanged, `err`=1. After `rst`, `err`=0.
- **Replace-top:**
  - Stack holds 0x0A,0x0B; push 0xCC with pop -> next cycle `dout`=0x0B, `dout_valid`=1, `count`=2.
  - A following pop returns 0xCC.
- **Empty push+pop:** when empty, push 0x7E with pop -> `count`=1, no `dout_valid`. The next pop returns 0x7E.
